// File: rtl/weight_ram_scheduler.sv
// Sequencer/arbiter for the divided-clock weight RAM: init phase after reset, then
// read/write arbitration. Optional macro WR_PRIORITY_EN makes writes beat reads.
module weight_ram_scheduler #(
  parameter int N           = 10,
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 65,
  parameter int RAM_LAT     = 4,
  parameter int INIT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_init,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              addr_err,
  output logic              ram_in,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic              init_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(INIT_CYCLES * RAM_LAT + RAM_LAT + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES * RAM_LAT - 1);
  localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(RAM_LAT - 1);
  localparam logic [ADDR_W:0]  N_X       = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_READY, S_RD, S_WR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_gnt_d, wr_gnt_d, err_d;
  logic              pick_rd, pick_wr;
  logic              rd_bad, wr_bad;

  // Extended by one bit so addresses near the top cannot wrap into range.
  assign rd_bad = ({1'b0, rd_addr} + N_X) > DEPTH_X;
  assign wr_bad = ({1'b0, wr_addr} + N_X) > DEPTH_X;

`ifdef WR_PRIORITY_EN
  assign pick_wr = wr_req;
`else
  logic prefer_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        prefer_rd <= 1'b1;
    else if (rd_gnt_d) prefer_rd <= 1'b0;
    else if (wr_gnt_d) prefer_rd <= 1'b1;
  end

  assign pick_wr = wr_req && (!rd_req || !prefer_rd);
`endif
  assign pick_rd = rd_req && !pick_wr;

  // NOTE: every variable gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = ram_address;
    rd_gnt_d = 1'b0;
    wr_gnt_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_INIT: begin
        // cnt counts cycles ram_in has actually been high, so reset entry and
        // start_init entry give the same init length.
        if (ram_in) begin
          if (cnt_q == INIT_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_READY: begin
        if (start_init) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else if (pick_rd) begin
          rd_gnt_d = 1'b1;
          if (rd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RD;
            addr_d  = rd_addr;
            cnt_d   = '0;
          end
        end else if (pick_wr) begin
          wr_gnt_d = 1'b1;
          if (wr_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WR;
            addr_d  = wr_addr;
            cnt_d   = '0;
          end
        end
      end
      S_RD, S_WR: begin
        if (cnt_q == OP_LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // Outputs are registered from the next state so reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      rd_gnt      <= 1'b0;
      wr_gnt      <= 1'b0;
      addr_err    <= 1'b0;
      rd_valid    <= 1'b0;
      wr_done     <= 1'b0;
      ram_in      <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      init_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_gnt      <= rd_gnt_d;
      wr_gnt      <= wr_gnt_d;
      addr_err    <= err_d;
      rd_valid    <= (state_d == S_RD) && (cnt_d == OP_LAST);
      wr_done     <= (state_d == S_WR) && (cnt_d == OP_LAST);
      ram_in      <= (state_d == S_INIT);
      ram_we      <= (state_d == S_WR);
      ram_address <= addr_d;
      init_done   <= (state_d != S_INIT);
      busy        <= (state_d != S_READY);
    end
  end

endmodule
